tone_player_ctrl: RTL
=====================

// Module: tone_player_ctrl
// PURPOSE
//   Controller that sequences the 100-entry sine tone table for the audio path.
//   - Generates the sample_end strobe from the system clock.
//   - Steps the table index with a programmable increment, which sets the tone pitch.
//   - Runs a start/stop state machine with linear fade-in and fade-out.
//   - Sits between the control logic and the tone ROM; audio_out feeds the effects chain.
// PARAMETERS
//   CLK_DIV    1024  clocks per audio sample (sample_end period); must be >= 2
//   TABLE_LEN  100   number of entries in the tone table (index wraps at this value)
// PORTS
//   clk          in   1   system clock
//   reset        in   1   synchronous, active-high reset
//   start        in   1   single-cycle request to begin playback
//   stop         in   1   single-cycle request to fade out and end playback
//   step         in   7   table increment per sample; latched when start is accepted
//   rom_index    out  7   address to the tone table
//   rom_data     in   16  signed table word; combinational from rom_index, same cycle
//   sample_end   out  1   one-clk strobe, once every CLK_DIV clocks
//   audio_out    out  16  signed, gain-scaled sample (registered)
//   state        out  2   0=IDLE 1=RAMP_UP 2=PLAY 3=RAMP_DOWN
//   busy         out  1   state != IDLE
// BEHAVIOUR
//   Reset:
//   - div_cnt=0, state=IDLE, gain=0, rom_index=0, step_l=1.
//   - audio_out=0, sample_end=0, busy=0.
//   Divider:
//   - div_cnt counts 0..CLK_DIV-1 and wraps; it free-runs in all states.
//   - sample_end=1 exactly when div_cnt==CLK_DIV-1.
//   Command sampling:
//   - start/stop are sampled every clk, not only on sample_end.
//   - The state change is visible on the next clk.
//   - start and stop in the same cycle: stop wins.
//   Step latch (on an accepted start):
//   - step==0 is latched as 1.
//   - step>=TABLE_LEN is latched as TABLE_LEN-1.
//   Transitions:
//   - IDLE: start -> RAMP_UP. stop is ignored.
//   - RAMP_UP: stop -> RAMP_DOWN, ramping down from the current gain; start is ignored.
//   - PLAY: stop -> RAMP_DOWN; start is ignored.
//   - RAMP_DOWN: start -> RAMP_UP from the current gain, re-latching step.
//   Gain (9-bit, 0..256), updated only on sample_end:
//   - RAMP_UP: gain+1; when the new value is 256, state -> PLAY at that same edge.
//   - RAMP_DOWN: gain-1; when the new value is 0, state -> IDLE, rom_index -> 0,
//     audio_out -> 0.
//   - IDLE and PLAY: gain is held.
//   On each sample_end while state != IDLE:
//   - audio_out <= ($signed(rom_data) * gain) >>> 8, arithmetic shift.
//   - rom_data and gain are the values present before that edge.
//   - Result truncated to 16 bits; at gain=256 it equals rom_data exactly.
//   - rom_index <= rom_index + step_l, minus TABLE_LEN if the sum >= TABLE_LEN.
//   Other timing rules:
//   - While IDLE, audio_out is held at 0 and rom_index at 0.
//   - audio_out latency: valid from the clk after the sample_end cycle; it holds
//     until the next sample_end.
//   - A command arriving in the same clk as sample_end: the sample is processed
//     under the old state, and the new state applies from the next clk.
//   - Reset asserted mid-operation returns every register to its reset value at
//     that edge; there is no fade.
// TESTING  (bench uses CLK_DIV=8)
//   1 Reset, then idle for 100 clks -> sample_end every 8th clk; audio_out=0;
//     rom_index=0; busy=0.
//   2 start with step=1, rom_data driven from the table ->
//     - state=PLAY after exactly 256 sample_ends.
//     - In PLAY, index 25 gives audio_out=16'h7fff.
//   3 In PLAY with step=3 -> rom_index sequence ...,96,99,2,5 (wrap mod 100).
//     step=0 start -> increments by 1. step=120 -> increments by 99.
//   4 Gain-scaling check:
//     - gain=128, rom_data=16'h7fff -> audio_out=16'h3fff.
//     - gain=128, rom_data=16'h8003 -> audio_out=16'hc001.
//   5 Stop cases:
//     - stop in PLAY -> RAMP_DOWN; IDLE after 256 sample_ends; audio_out=0; rom_index=0.
//     - stop in RAMP_UP at gain=100 -> IDLE after 100 sample_ends.
//     - start+stop same clk while IDLE -> stays IDLE.
//   6 Reset during PLAY -> next clk: state=0, audio_out=0, rom_index=0, div_cnt
//     restarts, and the first sample_end comes 8 clks later.

Source files
------------

// File: rtl/tone_player_ctrl.sv
// Tone table sequencer: sample-rate divider, pitch stepping through the tone table,
// and a start/stop state machine with linear fade-in/fade-out on the output gain.
module tone_player_ctrl #(
  parameter int CLK_DIV   = 1024,
  parameter int TABLE_LEN = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [6:0]  step,
  output logic [6:0]  rom_index,
  input  logic [15:0] rom_data,
  output logic        sample_end,
  output logic [15:0] audio_out,
  output logic [1:0]  state,
  output logic        busy
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(CLK_DIV - 2);
  localparam logic [7:0]       TLEN8    = 8'(TABLE_LEN);
  localparam logic [6:0]       MAX_STEP = 7'(TABLE_LEN - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    PLAY      = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  state_t           state_r;
  logic [DIV_W-1:0] div_cnt_r;
  logic             sample_end_r;
  logic [8:0]       gain_r;
  logic [6:0]       step_l_r;
  logic [6:0]       rom_index_r;
  logic [15:0]      audio_out_r;

  logic signed [25:0] product_s;
  logic [15:0]        audio_next_s;
  logic [7:0]         idx_sum_s;
  logic [6:0]         idx_next_s;

  // Zero steps would freeze the tone; oversize steps are clamped to one table lap.
  function automatic logic [6:0] clamp_step(input logic [6:0] s);
    logic [6:0] r;
    if (s == 7'd0) begin
      r = 7'd1;
    end else if ({1'b0, s} >= TLEN8) begin
      r = MAX_STEP;
    end else begin
      r = s;
    end
    return r;
  endfunction

  // Gain-scaled sample and wrapped next table index, both from pre-edge values.
  always_comb begin
    product_s    = 26'sd0;
    audio_next_s = 16'd0;
    idx_sum_s    = 8'd0;
    idx_next_s   = 7'd0;
    product_s    = $signed(rom_data) * $signed({1'b0, gain_r});
    audio_next_s = 16'(product_s >>> 8);
    idx_sum_s    = {1'b0, rom_index_r} + {1'b0, step_l_r};
    if (idx_sum_s >= TLEN8) begin
      idx_next_s = 7'(idx_sum_s - TLEN8);
    end else begin
      idx_next_s = idx_sum_s[6:0];
    end
  end

  // Divider, per-sample gain/index/audio update, then command-driven state changes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      div_cnt_r    <= '0;
      sample_end_r <= 1'b0;
      gain_r       <= 9'd0;
      step_l_r     <= 7'd1;
      rom_index_r  <= 7'd0;
      audio_out_r  <= 16'd0;
    end else begin
      div_cnt_r    <= (div_cnt_r == DIV_LAST) ? '0 : div_cnt_r + 1'b1;
      sample_end_r <= (div_cnt_r == DIV_PRE);

      if (sample_end_r) begin
        case (state_r)
          RAMP_UP: begin
            audio_out_r <= audio_next_s;
            rom_index_r <= idx_next_s;
            if (gain_r >= 9'd255) begin
              gain_r  <= 9'd256;
              state_r <= PLAY;
            end else begin
              gain_r <= gain_r + 9'd1;
            end
          end
          PLAY: begin
            audio_out_r <= audio_next_s;
            rom_index_r <= idx_next_s;
          end
          RAMP_DOWN: begin
            // Fade complete: park the output and index for the next start.
            if (gain_r <= 9'd1) begin
              gain_r      <= 9'd0;
              state_r     <= IDLE;
              rom_index_r <= 7'd0;
              audio_out_r <= 16'd0;
            end else begin
              gain_r      <= gain_r - 9'd1;
              audio_out_r <= audio_next_s;
              rom_index_r <= idx_next_s;
            end
          end
          default: begin
            audio_out_r <= 16'd0;
          end
        endcase
      end

      // Commands override any sample-driven transition made at this same edge.
      case (state_r)
        IDLE, RAMP_DOWN: begin
          if (start && !stop) begin
            state_r  <= RAMP_UP;
            step_l_r <= clamp_step(step);
          end
        end
        RAMP_UP, PLAY: begin
          if (stop) begin
            state_r <= RAMP_DOWN;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign rom_index  = rom_index_r;
  assign sample_end = sample_end_r;
  assign audio_out  = audio_out_r;
  assign state      = state_r;
  assign busy       = (state_r != IDLE);

endmodule
